// File: rtl/toggle_period_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_period_meter_if
//  Description : Signal bundle between a toggling source and the period
//                meter. Carries the signal under measurement towards the
//                meter and the measurement results back out of it.
//                  in_sig       : signal under measurement (async to clk)
//                  period       : last measured period, in clk cycles
//                  period_valid : one-cycle pulse, period updated
//                  locked       : period in tolerance for enough measurements
//                  timeout      : one-cycle pulse, input stopped toggling
//  Revision    : 1.0 - initial release
// ============================================================================
interface toggle_period_meter_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   in_sig;
    logic [COUNT_WIDTH-1:0] period;
    logic                   period_valid;
    logic                   locked;
    logic                   timeout;

    // Source / observer side: drives the signal, watches the results.
    modport master (
        output in_sig,
        input  period,
        input  period_valid,
        input  locked,
        input  timeout
    );

    // Meter side.
    modport slave (
        input  in_sig,
        output period,
        output period_valid,
        output locked,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/toggle_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_period_meter
//  Description : Measures the period of a slow toggling signal in system
//                clock cycles (rising edge to rising edge), reports each
//                measurement, asserts a lock flag after LOCK_COUNT
//                consecutive measurements within EXPECTED +/- TOLERANCE, and
//                pulses a timeout when no rising edge arrives for TIMEOUT
//                cycles.
//  Ports       : clk  - system clock, the only clock
//                rst  - asynchronous reset, active-high
//                bus  - toggle_period_meter_if.slave
//                       (in_sig in; period, period_valid, locked, timeout out)
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_period_meter #(
    parameter int          COUNT_WIDTH = 32,
    parameter int unsigned EXPECTED    = 3000000,
    parameter int unsigned TOLERANCE   = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT     = 6000000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    toggle_period_meter_if.slave   bus
);

    // ------------------------------------------------------------------
    // Elaboration-time constants
    // ------------------------------------------------------------------
    localparam logic [COUNT_WIDTH-1:0] c_lo_bound = COUNT_WIDTH'(EXPECTED - TOLERANCE);
    localparam logic [COUNT_WIDTH-1:0] c_hi_bound = COUNT_WIDTH'(EXPECTED + TOLERANCE);
    // Counter value in the last cycle before a timeout fires.
    localparam logic [COUNT_WIDTH-1:0] c_cnt_last = COUNT_WIDTH'(TIMEOUT - 1);
    localparam logic [COUNT_WIDTH-1:0] c_cnt_one  = COUNT_WIDTH'(1);

    // Run counter only needs to reach LOCK_COUNT (it saturates there).
    localparam int                     c_run_w    = $clog2(LOCK_COUNT + 1);
    localparam logic [c_run_w-1:0]     c_run_full = c_run_w'(LOCK_COUNT);
    localparam logic [c_run_w-1:0]     c_run_one  = c_run_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   s1_q, s1_d;
    logic                   s2_q, s2_d;
    logic                   s3_q, s3_d;
    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [c_run_w-1:0]     run_q, run_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   w_rise;
    logic [COUNT_WIDTH-1:0] w_period_new;
    logic                   w_match;
    logic [c_run_w-1:0]     w_run_next;

    // s2 is the first metastability-safe copy; s3 is its one-cycle history.
    assign w_rise       = s2_q & ~s3_q;

    // Counter holds (cycles since the edge cycle) - 1 during the rise cycle,
    // so the +1 makes the reported period exact. The timeout keeps cnt_q
    // at or below TIMEOUT-1, so this never wraps.
    assign w_period_new = cnt_q + c_cnt_one;

    assign w_match      = (w_period_new >= c_lo_bound) && (w_period_new <= c_hi_bound);

    // Saturating run of consecutive in-tolerance measurements.
    always_comb begin
        w_run_next = '0;
        if (w_match) begin
            if (run_q >= c_run_full) begin
                w_run_next = c_run_full;
            end else begin
                w_run_next = run_q + c_run_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_d           = bus.in_sig;
        s2_d           = s1_q;
        s3_d           = s2_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_d          = run_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // No reference edge yet: the first rise only starts timing.
                cnt_d = '0;
                if (w_rise) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (w_rise) begin
                    // An edge on the last counted cycle still wins over
                    // the timeout and is reported as period TIMEOUT.
                    period_d       = w_period_new;
                    period_valid_d = 1'b1;
                    cnt_d          = '0;
                    run_d          = w_run_next;
                    locked_d       = (w_run_next == c_run_full);
                end else if (cnt_q == c_cnt_last) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    run_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers (synchronizer included: a reset mid-stream must not leave
    // a stale high in the chain that would fake an edge afterwards)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            run_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_q          <= run_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all straight from flops
    // ------------------------------------------------------------------
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toggle_period_meter
//  Description : Directed self-checking bench for toggle_period_meter with
//                COUNT_WIDTH=8, EXPECTED=10, TOLERANCE=1, LOCK_COUNT=3,
//                TIMEOUT=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_period_meter;

    localparam int c_cw = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    toggle_period_meter_if #(.COUNT_WIDTH(c_cw)) bus ();

    toggle_period_meter #(
        .COUNT_WIDTH (c_cw),
        .EXPECTED    (10),
        .TOLERANCE   (1),
        .LOCK_COUNT  (3),
        .TIMEOUT     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int prev_len = 0;   // length of the previous pulse() = period measured by the next rise

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a rising edge now, then stay in the pulse for len cycles
    // (high for len/2). The rise is reported 3 steps after it is driven
    // (2 synchronizer edges + 1 registered output edge).
    task automatic pulse(input int len, input bit exp_pv, input bit exp_locked);
        bus.in_sig = 1'b1;
        for (int s = 1; s <= len; s++) begin
            step();
            if (s == len / 2) bus.in_sig = 1'b0;
            if (s == 2) begin
                n_checks++;
                if (bus.period_valid !== 1'b0)
                    $display("FAIL early_pv: period_valid=%b required 0 (len %0d)", bus.period_valid, len);
                else n_pass++;
            end
            if (s == 3) begin
                n_checks++;
                if (bus.period_valid !== exp_pv)
                    $display("FAIL pv: period_valid=%b required %b (len %0d)", bus.period_valid, exp_pv, len);
                else n_pass++;
                if (exp_pv) begin
                    n_checks++;
                    if (bus.period !== c_cw'(prev_len))
                        $display("FAIL period: period=%0d required %0d", bus.period, prev_len);
                    else n_pass++;
                end
                n_checks++;
                if (bus.locked !== exp_locked)
                    $display("FAIL locked: locked=%b required %b (len %0d)", bus.locked, exp_locked, len);
                else n_pass++;
                n_checks++;
                if (bus.timeout !== 1'b0)
                    $display("FAIL no_timeout: timeout=%b required 0", bus.timeout);
                else n_pass++;
            end
        end
        prev_len = len;
    endtask

    task automatic test_reset();
        bus.in_sig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.in_sig = ~bus.in_sig;
            n_checks++;
            if ({bus.period, bus.period_valid, bus.locked, bus.timeout} !== '0)
                $display("FAIL reset_outs: period=%0d pv=%b locked=%b timeout=%b required all 0",
                         bus.period, bus.period_valid, bus.locked, bus.timeout);
            else n_pass++;
        end
        bus.in_sig = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_period_and_lock();
        pulse(10, 1'b0, 1'b0);   // first rise: no report
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b1);   // third report locks
    endtask

    task automatic test_tolerance();
        pulse(9,  1'b1, 1'b1);   // reports 10
        pulse(11, 1'b1, 1'b1);   // reports 9
        pulse(12, 1'b1, 1'b1);   // reports 11
        pulse(10, 1'b1, 1'b0);   // reports 12 -> unlock
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b1);   // relock
    endtask

    // Last rise was driven 10 steps ago; its detection cycle ends at step 3,
    // so the timeout lands 32 cycles later, at step 35 = 25 steps from here.
    task automatic test_timeout();
        int early = 0;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k < 25 && (bus.timeout !== 1'b0 || bus.locked !== 1'b1)) early++;
            if (k == 25) begin
                n_checks++;
                if (bus.timeout !== 1'b1)
                    $display("FAIL timeout_pulse: timeout=%b required 1", bus.timeout);
                else n_pass++;
                n_checks++;
                if (bus.locked !== 1'b0)
                    $display("FAIL timeout_unlock: locked=%b required 0", bus.locked);
                else n_pass++;
            end
            if (k == 26) begin
                n_checks++;
                if (bus.timeout !== 1'b0)
                    $display("FAIL timeout_width: timeout=%b required 0", bus.timeout);
                else n_pass++;
            end
        end
        n_checks++;
        if (early != 0)
            $display("FAIL timeout_early: %0d bad cycles required 0", early);
        else n_pass++;
        pulse(32, 1'b0, 1'b0);   // rise after timeout: no report
    endtask

    task automatic test_edge_at_timeout();
        pulse(10, 1'b1, 1'b0);   // reports 32, no timeout, mismatch
    endtask

    task automatic test_reset_mid_period();
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b1);
        bus.in_sig = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.period, bus.period_valid, bus.locked, bus.timeout} !== '0)
            $display("FAIL async_reset: period=%0d pv=%b locked=%b timeout=%b required all 0",
                     bus.period, bus.period_valid, bus.locked, bus.timeout);
        else n_pass++;
        bus.in_sig = 1'b0;
        step();
        step();
        rst = 1'b0;
        pulse(10, 1'b0, 1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(10, 1'b1, 1'b1);
    endtask

    initial begin
        bus.in_sig = 1'b0;
        test_reset();
        test_period_and_lock();
        test_tolerance();
        test_timeout();
        test_edge_at_timeout();
        test_reset_mid_period();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
